// File: rtl/lh_ootx_frame_ctrl.sv
// OOTX receive-path frame controller: sequences length/payload/pad/CRC32 words,
// runs a bit-serial reflected CRC-32 and publishes verified frames from a ping-pong byte buffer.
module lh_ootx_frame_ctrl #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] word_i,
    input  logic [7:0]  wordAddr_i,
    input  logic        wordValid_i,
    input  logic        frameAck_i,
    input  logic [7:0]  rdAddr_i,
    output logic [7:0]  rdData_o,
    output logic        frameValid_o,
    output logic [7:0]  frameLen_o,
    output logic        busy_o,
    output logic        statCrcErr_o,
    output logic        statDrop_o,
    output logic        statAbort_o
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [7:0]  MAX_LEN  = 8'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        CRC_LO,
        CRC_HI,
        CHECK
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  exp_q, exp_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic [31:0] rxCrc_q, rxCrc_d;
    logic        bank_q, bank_d;
    logic        frameValid_q, frameValid_d;
    logic [7:0]  frameLen_q, frameLen_d;
    logic [7:0]  rdData_q;
    logic        statCrcErr_q, statCrcErr_d;
    logic        statDrop_q, statDrop_d;
    logic        statAbort_q, statAbort_d;

    logic        engineBusy;
    logic        lenOk;
    logic        crcMatch;
    logic        startFrame;
    logic        wrLo, wrHi;
    logic [7:0]  wrIdxLo, wrIdxHi;

    // Both banks live in one array; the bank bit is the top address bit.
    logic [7:0]  mem [256];

    assign engineBusy = (bitCnt_q != 5'd0);
    assign lenOk      = (word_i[15:8] == 8'h00) && (word_i[7:0] != 8'h00) && (word_i[7:0] <= MAX_LEN);
    assign crcMatch   = ((crc_q ^ 32'hFFFF_FFFF) == rxCrc_q);
    assign wrIdxLo    = {~bank_q, wordAddr_i[6:0] - 7'd2};
    assign wrIdxHi    = {~bank_q, wordAddr_i[6:0] - 7'd1};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        exp_d        = exp_q;
        crc_d        = crc_q;
        shift_d      = shift_q;
        bitCnt_d     = bitCnt_q;
        rxCrc_d      = rxCrc_q;
        bank_d       = bank_q;
        frameValid_d = frameValid_q & ~frameAck_i;
        frameLen_d   = frameLen_q;
        statCrcErr_d = 1'b0;
        statDrop_d   = 1'b0;
        statAbort_d  = 1'b0;
        wrLo         = 1'b0;
        wrHi         = 1'b0;
        startFrame   = 1'b0;

        // One reflected CRC step per cycle, LSB of the queued bytes first.
        if (engineBusy) begin
            crc_d    = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ shift_q[0]) ? CRC_POLY : 32'h0);
            shift_d  = {1'b0, shift_q[15:1]};
            bitCnt_d = bitCnt_q - 5'd1;
        end

        case (state_q)
            IDLE: begin
                if (wordValid_i && (wordAddr_i == 8'd0)) begin
                    if (lenOk) begin
                        startFrame = 1'b1;
                    end else begin
                        statAbort_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!crcMatch) begin
                    statCrcErr_d = 1'b1;
                end else if (frameValid_q && !frameAck_i) begin
                    statDrop_d = 1'b1;
                end else begin
                    frameValid_d = 1'b1;
                    frameLen_d   = len_q;
                    bank_d       = ~bank_q;
                end
            end
            default: begin
                if (wordValid_i) begin
                    if (wordAddr_i != exp_q) begin
                        statAbort_d = 1'b1;
                        bitCnt_d    = 5'd0;
                        state_d     = IDLE;
                        if ((wordAddr_i == 8'd0) && lenOk) begin
                            startFrame = 1'b1;
                        end
                    end else if (engineBusy) begin
                        statAbort_d = 1'b1;
                        bitCnt_d    = 5'd0;
                        state_d     = IDLE;
                    end else begin
                        exp_d = exp_q + 8'd2;
                        if (state_q == PAYLOAD) begin
                            // The upper byte is payload unless it is the odd-length pad.
                            wrLo     = 1'b1;
                            wrHi     = (wordAddr_i <= len_q);
                            shift_d  = wrHi ? word_i : {8'h00, word_i[7:0]};
                            bitCnt_d = wrHi ? 5'd16 : 5'd8;
                            if (wordAddr_i >= len_q) begin
                                state_d = CRC_LO;
                            end
                        end else if (state_q == CRC_LO) begin
                            rxCrc_d[15:0] = word_i;
                            state_d       = CRC_HI;
                        end else begin
                            rxCrc_d[31:16] = word_i;
                            state_d        = CHECK;
                        end
                    end
                end
            end
        endcase

        if (startFrame) begin
            len_d    = word_i[7:0];
            exp_d    = 8'd2;
            crc_d    = 32'hFFFF_FFFF;
            bitCnt_d = 5'd0;
            state_d  = PAYLOAD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            len_q        <= 8'h00;
            exp_q        <= 8'h00;
            crc_q        <= 32'hFFFF_FFFF;
            shift_q      <= 16'h0000;
            bitCnt_q     <= 5'd0;
            rxCrc_q      <= 32'h0;
            bank_q       <= 1'b0;
            frameValid_q <= 1'b0;
            frameLen_q   <= 8'h00;
            statCrcErr_q <= 1'b0;
            statDrop_q   <= 1'b0;
            statAbort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            exp_q        <= exp_d;
            crc_q        <= crc_d;
            shift_q      <= shift_d;
            bitCnt_q     <= bitCnt_d;
            rxCrc_q      <= rxCrc_d;
            bank_q       <= bank_d;
            frameValid_q <= frameValid_d;
            frameLen_q   <= frameLen_d;
            statCrcErr_q <= statCrcErr_d;
            statDrop_q   <= statDrop_d;
            statAbort_q  <= statAbort_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wrLo) begin
            mem[wrIdxLo] <= word_i[7:0];
        end
        if (wrHi) begin
            mem[wrIdxHi] <= word_i[15:8];
        end
    end

    // Reads only ever see the published bank.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdData_q <= 8'h00;
        end else if (rdAddr_i < MAX_LEN) begin
            rdData_q <= mem[{bank_q, rdAddr_i[6:0]}];
        end else begin
            rdData_q <= 8'h00;
        end
    end

    assign rdData_o     = rdData_q;
    assign frameValid_o = frameValid_q;
    assign frameLen_o   = frameLen_q;
    assign busy_o       = (state_q != IDLE);
    assign statCrcErr_o = statCrcErr_q;
    assign statDrop_o   = statDrop_q;
    assign statAbort_o  = statAbort_q;

endmodule

// File: doc/lh_ootx_frame_ctrl.md
# lh_ootx_frame_ctrl

Frame-level controller for the Lighthouse OOTX receive path. It consumes the 16-bit word stream from the OOTX bit-level decoder, sequences length, payload, padding and CRC32 fields, and runs a bit-serial CRC32 engine over the payload. It stores payload bytes in a ping-pong byte buffer and publishes each verified frame to the base-station-info consumer through a valid/ack handshake.

## Interface
- MAX_PAYLOAD, default 64: maximum accepted payload length in bytes. Range 1..128. Each bank holds MAX_PAYLOAD bytes.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- WORD_IN  in  16  decoder word. [7:0] is the earlier-received byte, [15:8] the later.
- WORD_ADDR  in  8  stream byte offset of WORD_IN[7:0]. Always even; 0 marks a new frame.
- WORD_VALID  in  1  one-cycle strobe. Upstream guarantees at least 17 CLK cycles between strobes.
- FRAME_ACK  in  1  consumer releases the published frame. One-cycle pulse.
- RD_ADDR  in  8  byte index into the published frame.
- RD_DATA  out  8  published byte at RD_ADDR, registered, 1-cycle latency.
- FRAME_VALID  out  1  level. A verified frame is published.
- FRAME_LEN  out  8  payload length of the published frame. Held while FRAME_VALID is high.
- BUSY  out  1  high when FSM state is not IDLE.
- STAT_CRC_ERR  out  1  one-cycle pulse on CRC mismatch.
- STAT_DROP  out  1  one-cycle pulse when a good frame is discarded because the read bank is still held.
- STAT_ABORT  out  1  one-cycle pulse on sequence, length or overrun error.

## Operation
- Stream layout:
  - Offset 0..1: payload length L, little-endian. The upper byte must be 0.
  - Offset 2..L+1: payload.
  - One pad byte follows if L is odd. It is not stored and not CRC'd.
  - Next 4 bytes: CRC32, little-endian.
- Expected offset E is tracked by the FSM and advances by 2 per accepted word.
- FSM states: IDLE, PAYLOAD, CRC_LO, CRC_HI, CHECK.
  - IDLE: wait for WORD_VALID with WORD_ADDR==0. Validate L: 1 ≤ L ≤ MAX_PAYLOAD and WORD_IN[15:8]==0. On pass, latch L, preset CRC to 0xFFFFFFFF, set E=2, go to PAYLOAD. On fail, pulse STAT_ABORT and stay in IDLE.
  - PAYLOAD: on each word, write the 1 or 2 payload bytes into the write bank at index WORD_ADDR-2. Queue those bytes to the CRC engine. After the word covering byte L+1 (which includes the pad if any), go to CRC_LO.
  - CRC_LO / CRC_HI: capture bytes 0..1, then bytes 2..3 of the received CRC.
  - CHECK: occupies one cycle, entered only once the engine is idle. Compare the engine result XOR 0xFFFFFFFF against the received CRC.
    - Match and FRAME_VALID low: swap banks, load FRAME_LEN=L, set FRAME_VALID.
    - Match and FRAME_VALID high: pulse STAT_DROP.
    - Mismatch: pulse STAT_CRC_ERR.
    - In all cases, return to IDLE.
- CRC engine: reflected IEEE CRC-32, polynomial 0xEDB88320. Processes one bit per cycle, LSB-first within each byte, earlier byte first. Takes 16 cycles for two bytes, 8 for one.
- Sequence errors, from any non-IDLE state:
  - WORD_VALID with WORD_ADDR != E: pulse STAT_ABORT. If WORD_ADDR==0, treat the word as a fresh length word under the IDLE rules. Otherwise go to IDLE.
  - WORD_VALID while the CRC engine is busy: pulse STAT_ABORT and go to IDLE.
- Handshake:
  - FRAME_ACK with FRAME_VALID high clears FRAME_VALID and frees the read bank.
  - FRAME_ACK with FRAME_VALID low is ignored.
  - FRAME_ACK in the same cycle as a CHECK match: the ack is applied first, then the new frame is published. FRAME_VALID stays high and FRAME_LEN updates.
- RD_ADDR ≥ FRAME_LEN or FRAME_VALID low: RD_DATA is don't-care.
- Write bank contents are never visible on RD_DATA until the bank swap.

## Timing
- Reset values:
  - Outputs: FRAME_VALID=0, FRAME_LEN=0, RD_DATA=0, BUSY=0, all STAT_* = 0.
  - Internal: FSM=IDLE, CRC engine idle, bank select=0.
  - Buffer RAM is not reset.
- RST asserted mid-frame discards the frame silently (no STAT pulse) and deasserts FRAME_VALID.
- Latency: last CRC word's WORD_VALID in cycle T.
  - CHECK executes in cycle T+1.
  - FRAME_VALID or STAT_* is visible in cycle T+2.
- The CRC engine always finishes within 16 cycles of the last payload word, so it is idle by the time the CRC words arrive.
- STAT_* pulses last exactly one cycle. At most one STAT_* is asserted per cycle.
- BUSY rises the cycle after an accepted length word and falls the cycle after CHECK.
- RD_DATA reflects RD_ADDR from the previous cycle.

## Test plan
- Known vector. Payload "123456789", L=9. Words at offsets 0..14:
  - 0x0009, 0x3231, 0x3433, 0x3635, 0x3837, 0x0039 (pad byte 0x00 at offset 11), 0x3926, 0xCBF4. Spacing 17 cycles.
  - Required: FRAME_VALID at T+2, FRAME_LEN=9, RD_ADDR 0..8 returns 0x31..0x39, no STAT pulse.
- Same stream with the last word 0xCBF5: STAT_CRC_ERR one pulse, FRAME_VALID stays 0.
- Length words 0x0000, 0x0041 (MAX_PAYLOAD=64) and 0x0109: STAT_ABORT each time, BUSY stays 0.
- Gap and restart: offset 6 skipped (offset 8 arrives after 4), then a valid frame restarts at offset 0.
  - Required: one STAT_ABORT, then the second frame is published correctly.
- Hold and drop:
  - Two good frames with no FRAME_ACK: the second pulses STAT_DROP, and RD_DATA still returns frame 1.
  - Repeat with FRAME_ACK in the second frame's CHECK cycle: FRAME_VALID stays high and FRAME_LEN updates.
- Overrun and reset: WORD_VALID 5 cycles after a payload word gives STAT_ABORT. RST mid-payload returns BUSY=0, FRAME_VALID=0 and no STAT pulse next cycle.
